// File: rtl/mem_checkpoint_monitor_pkg.sv
// Shared constants, state/code types and the checkpoint code decoder for the
// firmware checkpoint monitor.
package mem_checkpoint_monitor_pkg;

   localparam logic [7:0] START_HI = 8'hA0;
   localparam logic [7:0] RES_HI   = 8'hAB;
   localparam logic [7:0] TAG_BASE = 8'h10;
   localparam logic [7:0] PASS_BIT = 8'h01;
   localparam int         MAX_CH   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      K_NONE  = 2'd0,
      K_START = 2'd1,
      K_PASS  = 2'd2,
      K_FAIL  = 2'd3
   } kind_t;

   typedef struct packed {
      kind_t      kind;
      logic [1:0] ch;
   } code_info_t;

   // Channel i uses tag 8'h10 << i; codes for channels >= num_ch decode as K_NONE.
   function automatic code_info_t decode_code(input logic [15:0] code, input int num_ch);
      code_info_t info;
      logic [7:0] tag;
      info.kind = K_NONE;
      info.ch   = 2'd0;
      for (int i = 0; i < MAX_CH; i++) begin
         tag = TAG_BASE << i;
         if (i < num_ch) begin
            if (code == {START_HI, tag}) begin
               info.kind = K_START;
               info.ch   = 2'(i);
            end else if (code == {RES_HI, tag}) begin
               info.kind = K_FAIL;
               info.ch   = 2'(i);
            end else if (code == {RES_HI, tag | PASS_BIT}) begin
               info.kind = K_PASS;
               info.ch   = 2'(i);
            end
         end
      end
      return info;
   endfunction

endpackage

// File: rtl/mem_checkpoint_monitor_debounce.sv
// Glitch filter for the checkpoint field: a value is accepted once after it has
// held for STABLE_CYCLES registered samples and differs from the last accepted value.
module ckpt_debounce #(
   parameter int W             = 16,
   parameter int STABLE_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [W-1:0] din,
   output logic         acc_valid,
   output logic [W-1:0] acc_code
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);

   logic [W-1:0]  in_q;
   logic [W-1:0]  last_q;
   logic [SW-1:0] cnt_q;
   logic          accept;

   // Handshake: acc_valid is a one-cycle strobe, acc_code is valid in the same
   // cycle; the consumer has no ready and must take the code when it is offered.
   assign accept = (cnt_q == SW'(STABLE_CYCLES)) && (in_q != last_q) && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q      <= '0;
         cnt_q     <= '0;
         last_q    <= '0;
         acc_valid <= 1'b0;
         acc_code  <= '0;
      end else begin
         in_q <= din;
         if (din == in_q) begin
            if (cnt_q != SW'(STABLE_CYCLES)) cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= SW'(1);
         end
         acc_valid <= accept;
         if (accept) acc_code <= in_q;
         // Forgetting the last code while disarmed lets a rerun reuse the same sequence.
         if (clr)         last_q <= '0;
         else if (accept) last_q <= in_q;
      end
   end

endmodule

// File: rtl/mem_checkpoint_monitor.sv
// Checkpoint monitor: tracks firmware start/pass/fail codes for NUM_CH phases in
// descending order with a RUN-cycle timeout and sticky verdicts.
module mem_checkpoint_monitor
   import mem_checkpoint_monitor_pkg::*;
#(
   parameter int NUM_CH         = 3,
   parameter int STABLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 300000,
   parameter int CNT_W          = 20
) (
   input  logic              core_clk,
   input  logic              core_rstn,
   input  logic              enable,
   input  logic [15:0]       checkbits,
   output logic [1:0]        state,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [NUM_CH-1:0] ch_started,
   output logic [NUM_CH-1:0] ch_passed,
   output logic [15:0]       fail_code,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam logic [1:0]       LAST_CH = 2'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       rst_sync_q;
   logic             rst_n;
   logic             acc_valid;
   logic [15:0]      acc_code;
   code_info_t       info;
   logic             hit;

   state_t           state_q, state_d;
   logic [1:0]       exp_q, exp_d;
   logic [3:0]       started_q, started_d;
   logic [3:0]       passed_q, passed_d;
   logic [15:0]      code_q, code_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Reset asserts asynchronously and releases on the clock.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) rst_sync_q <= 2'b00;
      else            rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   ckpt_debounce #(
      .W             (16),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_debounce (
      .clk       (core_clk),
      .rst_n     (rst_n),
      .clr       (!enable),
      .din       (checkbits),
      .acc_valid (acc_valid),
      .acc_code  (acc_code)
   );

   assign info = decode_code(acc_code, NUM_CH);
   assign hit  = acc_valid && (info.kind != K_NONE);

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         exp_q     <= LAST_CH;
         started_q <= '0;
         passed_q  <= '0;
         code_q    <= '0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         started_q <= started_d;
         passed_q  <= passed_d;
         code_q    <= code_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      started_d = started_q;
      passed_d  = passed_q;
      code_d    = code_q;
      timeout_d = timeout_q;
      cnt_d     = cnt_q;
      if (!enable) begin
         state_d   = ST_IDLE;
         exp_d     = LAST_CH;
         started_d = '0;
         passed_d  = '0;
         code_d    = '0;
         timeout_d = 1'b0;
         cnt_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
            ST_RUN: begin
               if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
               if (hit) begin
                  case (info.kind)
                     K_START: begin
                        if (info.ch == exp_q) begin
                           started_d[exp_q] = 1'b1;
                        end else begin
                           state_d = ST_FAIL;
                           code_d  = acc_code;
                        end
                     end
                     K_PASS: begin
                        if ((info.ch == exp_q) && started_q[exp_q]) begin
                           passed_d[exp_q] = 1'b1;
                           if (exp_q == 2'd0) state_d = ST_PASS;
                           else               exp_d   = exp_q - 1'b1;
                        end else begin
                           state_d = ST_FAIL;
                           code_d  = acc_code;
                        end
                     end
                     default: begin
                        state_d = ST_FAIL;
                        code_d  = acc_code;
                     end
                  endcase
               end else if (cnt_q >= TO_LAST) begin
                  // >= keeps the timeout live if an accept pre-empted the exact cycle.
                  state_d   = ST_FAIL;
                  timeout_d = 1'b1;
                  code_d    = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign state       = state_q;
   assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
   assign pass        = (state_q == ST_PASS);
   assign fail        = (state_q == ST_FAIL);
   assign timeout     = timeout_q;
   assign ch_started  = started_q[NUM_CH-1:0];
   assign ch_passed   = passed_q[NUM_CH-1:0];
   assign fail_code   = code_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_mem_checkpoint_monitor.sv
// Directed bench for mem_checkpoint_monitor with NUM_CH=3, STABLE_CYCLES=2, TIMEOUT_CYCLES=100.
module tb_mem_checkpoint_monitor;

   logic        core_clk;
   logic        core_rstn;
   logic        enable;
   logic [15:0] checkbits;
   logic [1:0]  state;
   logic        done, pass, fail, timeout;
   logic [2:0]  ch_started, ch_passed;
   logic [15:0] fail_code;
   logic [19:0] cycle_count;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   mem_checkpoint_monitor #(
      .NUM_CH         (3),
      .STABLE_CYCLES  (2),
      .TIMEOUT_CYCLES (100),
      .CNT_W          (20)
   ) dut (
      .core_clk    (core_clk),
      .core_rstn   (core_rstn),
      .enable      (enable),
      .checkbits   (checkbits),
      .state       (state),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .ch_started  (ch_started),
      .ch_passed   (ch_passed),
      .fail_code   (fail_code),
      .cycle_count (cycle_count)
   );

   // clock / reset
   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic tick(input int n);
      repeat (n) @(posedge core_clk);
      #1;
   endtask

   task automatic hold(input logic [15:0] code, input int n);
      checkbits = code;
      tick(n);
   endtask

   task automatic restart();
      enable    = 1'b0;
      checkbits = 16'h0000;
      tick(2);
      enable = 1'b1;
      tick(1);
   endtask

   task automatic run_nominal();
      hold(16'hA040, 5);
      hold(16'hAB41, 5);
      hold(16'hA020, 5);
      hold(16'hAB21, 5);
      hold(16'hA010, 5);
      hold(16'hAB11, 5);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_fail_code(input string tag);
      logic [15:0] e;
      e = exp_q.pop_front();
      chk(tag, fail_code, e);
   endtask

   initial begin
      // scoreboard of expected fail_code at each verdict, in test order
      exp_q.push_back(16'h0000);  // nominal pass
      exp_q.push_back(16'hAB40);  // fail code
      exp_q.push_back(16'hA010);  // out of order start
      exp_q.push_back(16'hAB41);  // pass without start
      exp_q.push_back(16'h0000);  // timeout
      exp_q.push_back(16'hAB40);  // accept beats timeout
      exp_q.push_back(16'h0000);  // rerun after enable drop

      core_rstn = 1'b0;
      enable    = 1'b0;
      checkbits = 16'h0000;
      tick(3);
      chk("rst_state", state, 2'd0);
      chk("rst_flags", {done, pass, fail, timeout}, 4'b0000);
      chk("rst_cnt", cycle_count, 20'd0);
      core_rstn = 1'b1;
      tick(3);

      // nominal
      restart();
      chk("run_state", state, 2'd1);
      hold(16'hA040, 5);
      chk("nom_started2", ch_started, 3'b100);
      hold(16'hAB41, 5);
      hold(16'hA020, 5);
      hold(16'hAB21, 5);
      hold(16'hA010, 5);
      chk("nom_pre_last", {state, ch_passed}, {2'd1, 3'b110});
      hold(16'hAB11, 5);
      chk("nom_state", state, 2'd2);
      chk("nom_flags", {done, pass, fail, timeout}, 4'b1100);
      chk("nom_passed", ch_passed, 3'b111);
      chk("nom_started", ch_started, 3'b111);
      chk_fail_code("nom_fail_code");
      hold(16'hAB40, 5);
      chk("nom_terminal", state, 2'd2);

      // fail code
      restart();
      hold(16'hA040, 5);
      hold(16'hAB40, 5);
      chk("fc_state", {state, done, fail}, {2'd3, 1'b1, 1'b1});
      chk("fc_passed", ch_passed, 3'b000);
      chk("fc_timeout", timeout, 1'b0);
      chk_fail_code("fc_fail_code");

      // order violations
      restart();
      hold(16'hA010, 5);
      chk("ord_start_state", state, 2'd3);
      chk_fail_code("ord_start_code");
      restart();
      hold(16'hAB41, 5);
      chk("ord_pass_state", state, 2'd3);
      chk_fail_code("ord_pass_code");

      // glitch filter and duplicate start
      restart();
      checkbits = 16'hA040;
      tick(1);
      checkbits = 16'h0000;
      tick(6);
      chk("gl_started", ch_started, 3'b000);
      chk("gl_state", state, 2'd1);
      hold(16'hA040, 5);
      chk("gl_set", {state, ch_started}, {2'd1, 3'b100});
      hold(16'h0000, 5);
      hold(16'hA040, 5);
      chk("gl_dup", {state, fail, ch_started}, {2'd1, 1'b0, 3'b100});

      // timeout after 100 RUN cycles
      restart();
      checkbits = 16'hA040;
      tick(99);
      chk("to_pre", {state, ch_started}, {2'd1, 3'b100});
      chk("to_pre_cnt", cycle_count, 20'd99);
      tick(1);
      chk("to_state", {state, done, fail, timeout}, {2'd3, 1'b1, 1'b1, 1'b1});
      chk("to_cnt", cycle_count, 20'd100);
      chk_fail_code("to_fail_code");
      tick(3);
      chk("to_cnt_frozen", cycle_count, 20'd100);

      // accept landing on the timeout cycle wins
      restart();
      checkbits = 16'hA040;
      tick(96);
      checkbits = 16'hAB40;
      tick(3);
      chk("tw_pre", state, 2'd1);
      tick(1);
      chk("tw_state", {state, timeout}, {2'd3, 1'b0});
      chk_fail_code("tw_fail_code");

      // async reset mid-RUN
      restart();
      hold(16'hA040, 5);
      core_rstn = 1'b0;
      #1;
      chk("ar_state", state, 2'd0);
      chk("ar_started", ch_started, 3'b000);
      chk("ar_cnt", cycle_count, 20'd0);
      tick(2);
      core_rstn = 1'b1;
      tick(3);

      // enable drop in PASS, then rerun
      restart();
      run_nominal();
      chk("en_pass", state, 2'd2);
      enable = 1'b0;
      tick(1);
      chk("en_idle", {state, done, pass}, {2'd0, 1'b0, 1'b0});
      chk("en_cleared", {ch_started, ch_passed}, 6'b000000);
      chk("en_cnt", cycle_count, 20'd0);
      restart();
      run_nominal();
      chk("rerun_state", {state, pass, ch_passed}, {2'd2, 1'b1, 3'b111});
      chk_fail_code("rerun_fail_code");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
